// File: rtl/cpu8.sv
// Single-cycle 8-bit register CPU: one 32-bit instruction executed per enabled clock.
// Optional multiplier for ACC UMT is compiled in when CPU_MUL_EN is defined.
module cpu8 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [31:0] instruction,
    output logic [7:0]  instruction_pointer,
    input  logic [7:0]  din,
    input  logic [7:0]  gpi,
    output logic [7:0]  reg_gout,
    output logic [7:0]  reg_dout,
    output logic [7:0]  reg_flag
);

    localparam logic [3:0] GRP_MOV = 4'h0;
    localparam logic [3:0] GRP_ACC = 4'h1;
    localparam logic [3:0] GRP_JMP = 4'h2;

    logic [7:0] ip_q;
    logic [7:0] gp_q [0:3];
    logic [7:0] dout_q;
    logic [7:0] gout_q;
    logic [3:0] flag_q;

    logic [3:0] group;
    logic [3:0] op;
    logic       src_is_reg;
    logic [7:0] src_field;
    logic       dst_is_reg;
    logic [7:0] dst_addr;
    logic       unused_bits;

    assign group      = instruction[31:28];
    assign op         = instruction[27:24];
    assign src_is_reg = instruction[23];
    assign src_field  = instruction[22:15];
    assign dst_is_reg = instruction[14];
    assign dst_addr   = instruction[13:6];
    assign unused_bits = ^{instruction[5:0], dst_addr[7:3]};

    logic [7:0] src_read;
    logic [7:0] s_val;
    logic [7:0] d_val;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] acc_res;
    logic       acc_valid;
    logic       new_c;
    logic       new_v;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flag_we;
    logic [3:0] flag_next;
    logic       jump_taken;

    // Register-file reads: only the low 3 address bits select a register.
    always_comb begin
        src_read = 8'h00;
        d_val    = 8'h00;
        case (src_field[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: src_read = gp_q[src_field[1:0]];
            3'd4:    src_read = din;
            3'd5:    src_read = gpi;
            3'd6:    src_read = dout_q;
            default: src_read = gout_q;
        endcase
        case (dst_addr[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: d_val = gp_q[dst_addr[1:0]];
            3'd4:    d_val = din;
            3'd5:    d_val = gpi;
            3'd6:    d_val = dout_q;
            default: d_val = gout_q;
        endcase
    end

    assign s_val = src_is_reg ? src_read : src_field;
    assign sum9  = {1'b0, d_val} + {1'b0, s_val};
    assign diff9 = {1'b0, d_val} - {1'b0, s_val};

`ifdef CPU_MUL_EN
    logic [15:0] prod16;
    assign prod16 = d_val * s_val;
`endif

    always_comb begin
        acc_res   = 8'h00;
        acc_valid = 1'b0;
        new_c     = 1'b0;
        new_v     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = d_val;
        flag_we   = 1'b0;
        flag_next = flag_q;
        jump_taken = 1'b0;

        case (op)
            4'd0: begin acc_res = sum9[7:0]; new_c = sum9[8]; acc_valid = 1'b1; end
            4'd1: begin
                acc_res = sum9[7:0];
                new_c   = sum9[8];
                new_v   = (d_val[7] == s_val[7]) && (sum9[7] != d_val[7]);
                acc_valid = 1'b1;
            end
            4'd2: begin
                acc_res = diff9[7:0];
                new_c   = diff9[8];
                new_v   = (d_val[7] != s_val[7]) && (diff9[7] != d_val[7]);
                acc_valid = 1'b1;
            end
`ifdef CPU_MUL_EN
            4'd3: begin acc_res = prod16[7:0]; new_c = |prod16[15:8]; acc_valid = 1'b1; end
`endif
            4'd4: begin acc_res = d_val & s_val; acc_valid = 1'b1; end
            4'd5: begin acc_res = d_val | s_val; acc_valid = 1'b1; end
            4'd6: begin acc_res = d_val ^ s_val; acc_valid = 1'b1; end
            default: ;
        endcase

        case (group)
            GRP_MOV: if (dst_is_reg) begin
                case (op)
                    4'd0: begin wr_en = 1'b1; wr_data = s_val; end
                    4'd1: begin wr_en = 1'b1; wr_data = {s_val[6:0], 1'b0}; end
                    4'd2: begin wr_en = 1'b1; wr_data = {1'b0, s_val[7:1]}; end
                    4'd3: begin wr_en = 1'b1; wr_data = ~s_val; end
                    default: ;
                endcase
            end
            GRP_ACC: if (dst_is_reg && acc_valid) begin
                wr_en     = 1'b1;
                wr_data   = acc_res;
                flag_we   = 1'b1;
                flag_next = {new_v, acc_res[7], new_c, (acc_res == 8'h00)};
            end
            GRP_JMP: begin
                case (op)
                    4'd0: jump_taken = 1'b1;
                    4'd1: jump_taken = flag_q[0];
                    4'd2: jump_taken = flag_q[1];
                    4'd3: jump_taken = flag_q[2];
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Reset overrides enable; writes to the read-only DIN/GPI addresses fall through.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ip_q    <= 8'h00;
            gp_q[0] <= 8'h00;
            gp_q[1] <= 8'h00;
            gp_q[2] <= 8'h00;
            gp_q[3] <= 8'h00;
            dout_q  <= 8'h00;
            gout_q  <= 8'h00;
            flag_q  <= 4'h0;
        end else if (enable) begin
            ip_q <= jump_taken ? s_val : ip_q + 8'd1;
            if (wr_en) begin
                case (dst_addr[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3: gp_q[dst_addr[1:0]] <= wr_data;
                    3'd6:    dout_q <= wr_data;
                    3'd7:    gout_q <= wr_data;
                    default: ;
                endcase
            end
            if (flag_we) flag_q <= flag_next;
        end
    end

    assign instruction_pointer = ip_q;
    assign reg_dout = dout_q;
    assign reg_gout = gout_q;
    assign reg_flag = {4'h0, flag_q};

endmodule

// File: tb/tb_cpu8.sv
// Scoreboard bench for cpu8: each driven instruction pushes hand-derived expected
// ip/dout/gout/flag values, popped and compared one clock later.
module tb_cpu8;

    localparam logic [3:0] MOV = 4'h0, ACC = 4'h1, JMP = 4'h2;
    localparam logic [7:0] R0 = 8'd0, R1 = 8'd1, R2 = 8'd2, R3 = 8'd3;
    localparam logic [7:0] DIN = 8'd4, GPI = 8'd5, DOUT = 8'd6, GOUT = 8'd7;

`ifdef CPU_MUL_EN
    localparam logic [7:0] UMT_GOUT = 8'h20, UMT_FLAG = 8'h02, SUB_GOUT = 8'hF0;
`else
    localparam logic [7:0] UMT_GOUT = 8'h10, UMT_FLAG = 8'h04, SUB_GOUT = 8'hE0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [7:0]  instruction_pointer;
    logic [7:0]  din = 8'hA5;
    logic [7:0]  gpi = 8'h3C;
    logic [7:0]  reg_gout;
    logic [7:0]  reg_dout;
    logic [7:0]  reg_flag;

    typedef struct {
        string      name;
        logic [7:0] ip;
        logic [7:0] dout;
        logic [7:0] gout;
        logic [7:0] flag;
    } expect_t;

    expect_t exp_q[$];
    int checks = 0;
    int errors = 0;

    cpu8 dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .instruction(instruction),
        .instruction_pointer(instruction_pointer),
        .din(din),
        .gpi(gpi),
        .reg_gout(reg_gout),
        .reg_dout(reg_dout),
        .reg_flag(reg_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [3:0] g, input logic [3:0] op,
                                        input logic sr, input logic [7:0] sv,
                                        input logic dr, input logic [7:0] da);
        return {g, op, sr, sv, dr, da, 6'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic en, input logic rstn,
                                 input logic [7:0] e_ip, input logic [7:0] e_dout,
                                 input logic [7:0] e_gout, input logic [7:0] e_flag);
        expect_t e;
        instruction = instr;
        enable      = en;
        resetn      = rstn;
        e.name = name; e.ip = e_ip; e.dout = e_dout; e.gout = e_gout; e.flag = e_flag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput({name, " queue"}, 8'h00, 8'h01);
        end else begin
            e = exp_q.pop_front();
            checkOutput({e.name, " ip"},   instruction_pointer, e.ip);
            checkOutput({e.name, " dout"}, reg_dout,            e.dout);
            checkOutput({e.name, " gout"}, reg_gout,            e.gout);
            checkOutput({e.name, " flag"}, reg_flag,            e.flag);
        end
    endtask

    initial begin
        applyStimulus("reset",      32'h0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus("reset_hold", 32'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

        applyStimulus("mov_dout", 32'h0000C180, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00);
        applyStimulus("mov_r0",   ins(MOV, 0, 0, 8'hC8, 1, R0),   1, 1, 8'h02, 8'h01, 8'h00, 8'h00);
        applyStimulus("uad_r0",   ins(ACC, 0, 0, 8'h50, 1, R0),   1, 1, 8'h03, 8'h01, 8'h00, 8'h02);
        applyStimulus("r0_dout",  ins(MOV, 0, 1, R0, 1, DOUT),    1, 1, 8'h04, 8'h18, 8'h00, 8'h02);
        applyStimulus("mov_r1",   ins(MOV, 0, 0, 8'h05, 1, R1),   1, 1, 8'h05, 8'h18, 8'h00, 8'h02);
        applyStimulus("sub_zero", ins(ACC, 2, 0, 8'h05, 1, R1),   1, 1, 8'h06, 8'h18, 8'h00, 8'h01);
        applyStimulus("jz_taken", ins(JMP, 1, 0, 8'h20, 1, R0),   1, 1, 8'h20, 8'h18, 8'h00, 8'h01);

        for (int i = 0; i < 3; i++)
            applyStimulus("disabled", ins(MOV, 0, 0, 8'h09, 1, GOUT), 0, 1, 8'h20, 8'h18, 8'h00, 8'h01);
        applyStimulus("enabled",  ins(MOV, 0, 0, 8'h09, 1, GOUT), 1, 1, 8'h21, 8'h18, 8'h09, 8'h01);

        applyStimulus("din_dout", ins(MOV, 0, 1, DIN, 1, DOUT),   1, 1, 8'h22, 8'hA5, 8'h09, 8'h01);
        applyStimulus("wr_din",   ins(MOV, 0, 0, 8'h07, 1, DIN),  1, 1, 8'h23, 8'hA5, 8'h09, 8'h01);
        applyStimulus("r0_gout",  ins(MOV, 0, 1, R0, 1, GOUT),    1, 1, 8'h24, 8'hA5, 8'h18, 8'h01);
        applyStimulus("shl",      ins(MOV, 1, 0, 8'h81, 1, DOUT), 1, 1, 8'h25, 8'h02, 8'h18, 8'h01);
        applyStimulus("shr_din",  ins(MOV, 2, 1, DIN, 1, GOUT),   1, 1, 8'h26, 8'h02, 8'h52, 8'h01);
        applyStimulus("not",      ins(MOV, 3, 0, 8'h0F, 1, DOUT), 1, 1, 8'h27, 8'hF0, 8'h52, 8'h01);
        applyStimulus("gpi_gout", ins(MOV, 0, 1, GPI, 1, GOUT),   1, 1, 8'h28, 8'hF0, 8'h3C, 8'h01);

        applyStimulus("mov_r2",   ins(MOV, 0, 0, 8'h70, 1, R2),   1, 1, 8'h29, 8'hF0, 8'h3C, 8'h01);
        applyStimulus("sad_ovf",  ins(ACC, 1, 0, 8'h20, 1, R2),   1, 1, 8'h2A, 8'hF0, 8'h3C, 8'h0C);
        applyStimulus("jn_taken", ins(JMP, 3, 0, 8'h40, 1, R0),   1, 1, 8'h40, 8'hF0, 8'h3C, 8'h0C);
        applyStimulus("jc_not",   ins(JMP, 2, 0, 8'h10, 1, R0),   1, 1, 8'h41, 8'hF0, 8'h3C, 8'h0C);
        applyStimulus("mov_r3",   ins(MOV, 0, 0, 8'hF0, 1, R3),   1, 1, 8'h42, 8'hF0, 8'h3C, 8'h0C);
        applyStimulus("xor_zero", ins(ACC, 6, 0, 8'hF0, 1, R3),   1, 1, 8'h43, 8'hF0, 8'h3C, 8'h01);
        applyStimulus("or_dout",  ins(ACC, 5, 0, 8'h0F, 1, DOUT), 1, 1, 8'h44, 8'hFF, 8'h3C, 8'h04);
        applyStimulus("mov_gout", ins(MOV, 0, 0, 8'h10, 1, GOUT), 1, 1, 8'h45, 8'hFF, 8'h10, 8'h04);
        applyStimulus("umt",      ins(ACC, 3, 0, 8'h12, 1, GOUT), 1, 1, 8'h46, 8'hFF, UMT_GOUT, UMT_FLAG);
        applyStimulus("sub_brw",  ins(ACC, 2, 0, 8'h30, 1, GOUT), 1, 1, 8'h47, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("jc_taken", ins(JMP, 2, 0, 8'hFF, 1, R0),   1, 1, 8'hFF, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("ip_wrap",  ins(MOV, 0, 0, 8'h03, 1, R0),   1, 1, 8'h00, 8'hFF, SUB_GOUT, 8'h06);

        applyStimulus("dst_num",  ins(MOV, 0, 0, 8'h33, 0, DOUT), 1, 1, 8'h01, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("bad_grp",  ins(4'h5, 0, 0, 8'h44, 1, DOUT), 1, 1, 8'h02, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("bad_jmp",  ins(JMP, 4, 0, 8'h80, 1, R0),   1, 1, 8'h03, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("bad_acc",  ins(ACC, 7, 0, 8'h01, 1, DOUT), 1, 1, 8'h04, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("jmp_dnum", ins(JMP, 0, 0, 8'h10, 0, R0),   1, 1, 8'h10, 8'hFF, SUB_GOUT, 8'h06);
        applyStimulus("and_r0",   ins(ACC, 4, 1, R0, 1, GOUT),    1, 1, 8'h11, 8'hFF, 8'h00, 8'h01);

        applyStimulus("rst_mid",  ins(MOV, 0, 0, 8'h01, 1, DOUT), 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus("post_dis", 32'h0000C180, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus("restart",  32'h0000C180, 1, 1, 8'h01, 8'h01, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
